// File: rtl/vga_timing_recovery_if.sv
// Sync inputs and recovered timing outputs exchanged between a sync source
// (master) and the vga_timing_recovery block (slave).
interface vga_timing_recovery_if;
   logic        hsync;
   logic        vsync;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        active;
   logic [10:0] hlen;
   logic [9:0]  vlen;
   logic        locked;
   logic        timing_err;

   modport master (
      output hsync,
      output vsync,
      input  x,
      input  y,
      input  active,
      input  hlen,
      input  vlen,
      input  locked,
      input  timing_err
   );

   modport slave (
      input  hsync,
      input  vsync,
      output x,
      output y,
      output active,
      output hlen,
      output vlen,
      output locked,
      output timing_err
   );
endinterface

// File: rtl/vga_timing_recovery.sv
// Recovers pixel position and an active-video flag from active-low hsync/vsync,
// measures line/frame lengths, declares lock after consecutive clean frames and
// pulses timing_err on any inconsistency. Everything runs on vgaclk.
module vga_timing_recovery #(
   parameter int HACTIVE     = 640,
   parameter int HFP         = 16,
   parameter int HSYN        = 96,
   parameter int VACTIVE     = 480,
   parameter int VFP         = 11,
   parameter int LOCK_FRAMES = 2
) (
   input logic                  vgaclk,
   input logic                  reset,
   vga_timing_recovery_if.slave bus
);
   localparam logic [10:0] HMAX   = 11'h7FF;
   localparam logic [9:0]  XMAX   = 10'h3FF;
   localparam logic [9:0]  LMAX   = 10'h3FF;
   localparam logic [9:0]  XLOAD  = 10'(HACTIVE + HFP);
   localparam logic [9:0]  YLOAD  = 10'(VACTIVE + VFP);
   localparam logic [9:0]  XACT   = 10'(HACTIVE);
   localparam logic [9:0]  YACT   = 10'(VACTIVE);
   localparam logic [10:0] HSYN_W = 11'(HSYN);
   localparam int          GW     = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

   logic          hs_q;
   logic          vs_q;
   logic [10:0]   hcnt;
   logic          hseen;
   logic [10:0]   hlen_q;
   logic [10:0]   hlow;
   logic          lost;
   logic [9:0]    xpos;
   logic [9:0]    ypos;
   logic [9:0]    lcnt;
   logic          vseen;
   logic [9:0]    vlen_q;
   logic [GW-1:0] goodcnt;
   logic          dirty;
   logic          locked_q;
   logic          err_q;

   logic          hfall;
   logic          vfall;
   logic          hrise;
   logic          xwrap;
   logic [10:0]   hmeas;
   logic          hlen_err;
   logic          vlen_err;
   logic          lost_err;
   logic          width_err;
   logic          err_now;
   logic [GW-1:0] goodnext;

   // Edge detection, line-wrap decision and the error sources for this cycle.
   // A line whose counter saturated is unmeasurable, so it never updates hlen.
   always_comb begin
      hfall     = hs_q & ~bus.hsync;
      vfall     = vs_q & ~bus.vsync;
      hrise     = ~hs_q & bus.hsync;
      hmeas     = hcnt + 11'd1;
      xwrap     = ~hfall & ~lost & (hlen_q != 11'd0) & ({1'b0, xpos} == (hlen_q - 11'd1));
      hlen_err  = hfall & hseen & (hcnt != HMAX) & (hlen_q != 11'd0) & (hmeas != hlen_q);
      vlen_err  = vfall & vseen & (vlen_q != 10'd0) & (lcnt != vlen_q);
      lost_err  = (hcnt == HMAX) & ~lost;
      width_err = hrise & (hlow != HSYN_W);
      err_now   = hlen_err | vlen_err | lost_err | width_err;
      goodnext  = (goodcnt == GOOD_TARGET) ? goodcnt : goodcnt + GW'(1);
   end

   // All timing state. Once hsync is lost the measured line length is no longer
   // trusted: x free-runs to saturation and the next hfall restarts measurement.
   always_ff @(posedge vgaclk) begin
      if (reset) begin
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         hcnt     <= '0;
         hseen    <= 1'b0;
         hlen_q   <= '0;
         hlow     <= '0;
         lost     <= 1'b0;
         xpos     <= '0;
         ypos     <= '0;
         lcnt     <= '0;
         vseen    <= 1'b0;
         vlen_q   <= '0;
         goodcnt  <= '0;
         dirty    <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         hs_q  <= bus.hsync;
         vs_q  <= bus.vsync;
         err_q <= err_now;

         if (hfall) begin
            if (hseen && (hcnt != HMAX)) begin
               hlen_q <= hmeas;
            end
            hcnt  <= '0;
            hseen <= 1'b1;
            lost  <= 1'b0;
         end else begin
            if (hcnt != HMAX) begin
               hcnt <= hcnt + 11'd1;
            end
            if (lost_err) begin
               lost  <= 1'b1;
               hseen <= 1'b0;
            end
         end

         if (!bus.hsync) begin
            if (hlow != HMAX) begin
               hlow <= hlow + 11'd1;
            end
         end else begin
            hlow <= '0;
         end

         if (hfall) begin
            xpos <= XLOAD;
         end else if (xwrap) begin
            xpos <= '0;
         end else if (xpos != XMAX) begin
            xpos <= xpos + 10'd1;
         end

         if (vfall) begin
            if (vseen) begin
               vlen_q <= lcnt;
            end
            lcnt  <= '0;
            vseen <= 1'b1;
         end else if (hfall && (lcnt != LMAX)) begin
            lcnt <= lcnt + 10'd1;
         end

         if (vfall) begin
            ypos <= YLOAD;
         end else if (xwrap) begin
            if ((vlen_q != 10'd0) && (ypos == (vlen_q - 10'd1))) begin
               ypos <= '0;
            end else if (ypos != XMAX) begin
               ypos <= ypos + 10'd1;
            end
         end

         if (err_now) begin
            locked_q <= 1'b0;
            goodcnt  <= '0;
            dirty    <= ~vfall;
         end else if (vfall) begin
            dirty <= 1'b0;
            if (vseen && !dirty) begin
               goodcnt <= goodnext;
               if (goodnext == GOOD_TARGET) begin
                  locked_q <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.x          = xpos;
   assign bus.y          = ypos;
   assign bus.hlen       = hlen_q;
   assign bus.vlen       = vlen_q;
   assign bus.locked     = locked_q;
   assign bus.timing_err = err_q;
   assign bus.active     = locked_q & (xpos < XACT) & (ypos < YACT);
endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery. A scaled-down VGA geometry (60 clocks x 26
// lines) keeps frames short; the sync source also produces the expected
// recovered position for every sample it drives.
module tb_vga_timing_recovery;
   localparam int HACTIVE     = 40;
   localparam int HFP         = 4;
   localparam int HSYN        = 8;
   localparam int HTOTAL      = 60;
   localparam int VACTIVE     = 20;
   localparam int VFP         = 2;
   localparam int VSYN        = 2;
   localparam int VTOTAL      = 26;
   localparam int LOCK_FRAMES = 2;
   localparam int SHORTLEN    = 55;
   localparam int FRAME       = HTOTAL * VTOTAL;

   typedef struct {
      logic valid;
      int   x;
      int   y;
   } posEntry_t;

   logic vgaclk = 1'b0;
   logic reset  = 1'b1;

   vga_timing_recovery_if busIf ();

   vga_timing_recovery #(
      .HACTIVE(HACTIVE),
      .HFP(HFP),
      .HSYN(HSYN),
      .VACTIVE(VACTIVE),
      .VFP(VFP),
      .LOCK_FRAMES(LOCK_FRAMES)
   ) dut (
      .vgaclk(vgaclk),
      .reset(reset),
      .bus(busIf.slave)
   );

   // Free-running pixel clock.
   always #5 vgaclk = ~vgaclk;

   posEntry_t posQ[$];
   int  checkCount   = 0;
   int  passCount    = 0;
   int  errPulses    = 0;
   int  activeCount  = 0;
   int  vfallsDriven = 0;
   int  gx           = 0;
   int  gy           = 0;
   int  shortRow     = -1;
   int  narrowRow    = -1;
   int  base         = 0;
   bit  forceIdle    = 1'b0;
   bit  checkPos     = 1'b0;
   bit  prevVs       = 1'b1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      assert (observed === expected) passCount = passCount + 1;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   // One clock: compare the position the DUT shows for the previous sample,
   // then drive the next generator sample and queue its expected position.
   task automatic applyStimulus();
      posEntry_t e;
      logic      hs;
      logic      vs;
      int        width;
      int        lineLen;
      @(posedge vgaclk);
      #1;
      if (posQ.size() != 0) begin
         e = posQ.pop_front();
         if (e.valid) begin
            checkOutput("pos_x", 32'(busIf.x), e.x);
            checkOutput("pos_y", 32'(busIf.y), e.y);
            checkOutput("pos_active", 32'(busIf.active), ((e.x < HACTIVE) && (e.y < VACTIVE)) ? 1 : 0);
         end
      end
      if (busIf.timing_err === 1'b1) errPulses++;
      if (busIf.active === 1'b1) activeCount++;
      width = (gy == narrowRow) ? HSYN - 1 : HSYN;
      hs = !((gx >= HACTIVE + HFP) && (gx < HACTIVE + HFP + width));
      vs = !((gy >= VACTIVE + VFP) && (gy < VACTIVE + VFP + VSYN));
      if (forceIdle) begin
         hs = 1'b1;
         vs = 1'b1;
      end
      if (prevVs && !vs) vfallsDriven++;
      prevVs = vs;
      busIf.hsync = hs;
      busIf.vsync = vs;
      e.valid = checkPos;
      e.x = gx;
      e.y = gy;
      posQ.push_back(e);
      lineLen = (gy == shortRow) ? SHORTLEN : HTOTAL;
      gx++;
      if (gx >= lineLen) begin
         gx = 0;
         if (gy == shortRow) shortRow = -1;
         if (gy == narrowRow) narrowRow = -1;
         gy = (gy + 1) % VTOTAL;
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic runUntilVfall(input int target);
      int budget;
      budget = (target - vfallsDriven + 1) * FRAME;
      while ((vfallsDriven < target) && (budget > 0)) begin
         applyStimulus();
         budget--;
      end
      if (vfallsDriven < target) checkOutput("vfall_wait_timeout", vfallsDriven, target);
   endtask

   task automatic runUntilPos(input int row, input int col);
      int budget;
      budget = 2 * FRAME;
      while (!((gy == row) && (gx == col)) && (budget > 0)) begin
         applyStimulus();
         budget--;
      end
      if (!((gy == row) && (gx == col))) checkOutput("pos_wait_timeout", gy * HTOTAL + gx, row * HTOTAL + col);
   endtask

   task automatic checkRelock(input string tag);
      base = vfallsDriven;
      runUntilVfall(base + 3);
      checkOutput({tag, "_locked_before"}, 32'(busIf.locked), 0);
      applyStimulus();
      checkOutput({tag, "_locked_after"}, 32'(busIf.locked), 1);
   endtask

   // Directed sequence: reset, lock, position, short line, narrow pulse,
   // mid-frame reset, lost sync.
   initial begin
      busIf.hsync = 1'b1;
      busIf.vsync = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge vgaclk);
      #1;
      checkOutput("rst_x", 32'(busIf.x), 0);
      checkOutput("rst_y", 32'(busIf.y), 0);
      checkOutput("rst_hlen", 32'(busIf.hlen), 0);
      checkOutput("rst_vlen", 32'(busIf.vlen), 0);
      checkOutput("rst_locked", 32'(busIf.locked), 0);
      checkOutput("rst_err", 32'(busIf.timing_err), 0);
      checkOutput("rst_active", 32'(busIf.active), 0);
      reset = 1'b0;
      errPulses = 0;

      $display("[TB] nominal stream to lock");
      runUntilVfall(1);
      checkOutput("hlen_nominal", 32'(busIf.hlen), HTOTAL);
      runUntilVfall(2);
      applyStimulus();
      checkOutput("vlen_nominal", 32'(busIf.vlen), VTOTAL);
      checkOutput("locked_vfall2", 32'(busIf.locked), 0);
      runUntilVfall(3);
      checkOutput("locked_before_vfall3", 32'(busIf.locked), 0);
      applyStimulus();
      checkOutput("locked_vfall3", 32'(busIf.locked), 1);
      checkOutput("err_during_lock", errPulses, 0);

      $display("[TB] recovered position over one frame");
      checkPos = 1'b1;
      activeCount = 0;
      runCycles(FRAME);
      checkOutput("active_count", activeCount, HACTIVE * VACTIVE);
      checkPos = 1'b0;
      applyStimulus();

      $display("[TB] shortened line");
      runUntilPos(2, 0);
      errPulses = 0;
      shortRow = 3;
      runCycles(5 * HTOTAL);
      checkOutput("short_err_pulses", errPulses, 2);
      checkOutput("short_locked", 32'(busIf.locked), 0);
      checkOutput("short_hlen_restored", 32'(busIf.hlen), HTOTAL);
      checkRelock("short_relock");

      $display("[TB] narrow hsync pulse");
      runUntilPos(2, 0);
      errPulses = 0;
      narrowRow = 3;
      runUntilPos(3, HACTIVE + HFP + HSYN - 1);
      applyStimulus();
      checkOutput("narrow_err_before", 32'(busIf.timing_err), 0);
      applyStimulus();
      checkOutput("narrow_err_pulse", 32'(busIf.timing_err), 1);
      applyStimulus();
      checkOutput("narrow_err_after", 32'(busIf.timing_err), 0);
      runCycles(3 * HTOTAL);
      checkOutput("narrow_err_pulses", errPulses, 1);
      checkOutput("narrow_locked", 32'(busIf.locked), 0);
      checkRelock("narrow_relock");

      $display("[TB] reset mid-frame");
      runUntilPos(10, 0);
      checkOutput("locked_before_reset", 32'(busIf.locked), 1);
      reset = 1'b1;
      applyStimulus();
      checkOutput("mid_rst_x", 32'(busIf.x), 0);
      checkOutput("mid_rst_y", 32'(busIf.y), 0);
      checkOutput("mid_rst_hlen", 32'(busIf.hlen), 0);
      checkOutput("mid_rst_vlen", 32'(busIf.vlen), 0);
      checkOutput("mid_rst_locked", 32'(busIf.locked), 0);
      checkOutput("mid_rst_err", 32'(busIf.timing_err), 0);
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      errPulses = 0;
      checkRelock("reset_relock");
      checkOutput("reset_no_spurious_err", errPulses, 0);

      $display("[TB] lost sync");
      runUntilPos(2, HACTIVE + HFP + HSYN);
      errPulses = 0;
      forceIdle = 1'b1;
      runCycles(3200);
      checkOutput("lost_err_pulses", errPulses, 1);
      checkOutput("lost_x_saturated", 32'(busIf.x), 1023);
      checkOutput("lost_locked", 32'(busIf.locked), 0);
      forceIdle = 1'b0;
      runCycles(2 * HTOTAL);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
